// File: rtl/setn_release_sequencer.sv
// setn_release_sequencer
// Staggered release of active-low set strobes (setn) for banks of
// negative-edge set-flops. An async active-high reset presets every bank
// at once; release is synchronized to clk and spread one bank every
// GAP_CYCLES so the downstream SETN pins never see simultaneous switching
// or a recovery/removal hazard. A run-time request re-presets all banks.
//
// Optional feature macro: SETN_SEQ_REQ_SYNC_EN
//   defined   : req goes through a 2-flop synchronizer and a rising-edge
//               detector; one request per req rise.
//   undefined : req is sampled raw as a level while the sequencer is done.
//
// State table
//   state      | meaning
//   ST_ASSERT  | all banks held set, counting HOLD_CYCLES after rst_s low
//   ST_RELEASE | releasing banks 1..NUM_BANKS-1, one every GAP_CYCLES
//   ST_DONE    | all banks released, waiting for a re-preset request

module setn_release_sequencer #(
  parameter int NUM_BANKS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  output logic [NUM_BANKS-1:0] setn,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BANK_W  = $clog2(NUM_BANKS) + 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [NUM_BANKS-1:0] setn_q, setn_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_s;
  logic                   req_take;

  // Reset-release synchronizer: async set, ones flushed out by zeros so
  // rst_s falls on the SYNC_STAGES-th edge after rst deasserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= '1;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_s = rst_sync_q[SYNC_STAGES-1];

`ifdef SETN_SEQ_REQ_SYNC_EN
  logic [2:0] req_q;

  // Two synchronizer stages plus one delay flop for the rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else begin
      req_q <= {req_q[1:0], req};
    end
  end

  // A held request produces a single one-cycle pulse.
  assign req_take = req_q[1] & ~req_q[2];
`else
  // Raw level: a request held high re-triggers on every return to done.
  assign req_take = req;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      bank_q  <= '0;
      setn_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      setn_q  <= setn_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output decode. setn shifts ones in from bit 0, so
  // bits can only rise one at a time and strictly in index order.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    setn_d  = setn_q;
    done_d  = done_q;

    case (state_q)
      ST_ASSERT: begin
        setn_d = '0;
        done_d = 1'b0;
        if (rst_s) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d  = '0;
          setn_d = NUM_BANKS'(1);
          bank_d = BANK_W'(1);
          if (NUM_BANKS == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d  = '0;
          setn_d = (setn_q << 1) | NUM_BANKS'(1);
          bank_d = bank_q + BANK_W'(1);
          if (bank_q == BANK_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        setn_d = '1;
        done_d = 1'b1;
        if (req_take) begin
          state_d = ST_ASSERT;
          setn_d  = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          bank_d  = '0;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        setn_d  = '0;
        done_d  = 1'b0;
        cnt_d   = '0;
        bank_d  = '0;
      end
    endcase

    busy_d = ~done_d;
  end

  assign setn = setn_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_setn_release_sequencer.sv
`timescale 1ns/1ps

module tb_setn_release_sequencer;

  localparam int N    = 4;
  localparam int SS   = 2;
  localparam int H    = 4;
  localparam int G    = 8;
  localparam int LAST = H + (N - 1) * G;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic         req  = 1'b0;
  logic         req1 = 1'b0;
  logic [N-1:0] setn;
  logic         busy, done;
  logic [0:0]   setn1;
  logic         busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int cyc        = 0;
  int rel        = 0;
  int t0         = 0;
  int e0         = 0;
  int rst_events = 0;
  int rst_seen   = 0;
  int model_acc  = 0;
  bit started    = 1'b0;
`ifdef SETN_SEQ_REQ_SYNC_EN
  bit prev_req   = 1'b0;
  int cand[$];
`endif

  always #5 clk = ~clk;

  setn_release_sequencer #(
    .NUM_BANKS(N), .SYNC_STAGES(SS), .HOLD_CYCLES(H), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .setn(setn), .busy(busy), .done(done)
  );

  setn_release_sequencer #(
    .NUM_BANKS(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)
  ) dut1 (
    .clk(clk), .rst(rst), .req(req1), .setn(setn1), .busy(busy1), .done(done1)
  );

  // Timeline model: t0 is the edge a sequence starts (rst_s fall or accepted
  // request); bank k is released once HOLD + k*GAP edges have passed.
  always @(posedge clk) begin : model
    bit was_done;
    bit take;
    if (rst_events != rst_seen) begin
      rst_seen = rst_events;
      started  = 1'b0;
      rel      = 0;
`ifdef SETN_SEQ_REQ_SYNC_EN
      prev_req = 1'b0;
      cand.delete();
`endif
    end
    was_done = started && (cyc - t0 >= LAST);
    cyc++;
    take = 1'b0;
    if (rst) begin
      started = 1'b0;
      rel     = 0;
`ifdef SETN_SEQ_REQ_SYNC_EN
      prev_req = 1'b0;
      cand.delete();
`endif
    end else begin
`ifdef SETN_SEQ_REQ_SYNC_EN
      while (cand.size() > 0 && cand[0] < cyc) void'(cand.pop_front());
      if (cand.size() > 0 && cand[0] == cyc) begin
        take = 1'b1;
        void'(cand.pop_front());
      end
      if (req && !prev_req) cand.push_back(cyc + 2);
      prev_req = req;
`else
      take = req;
`endif
      if (!started) begin
        rel++;
        if (rel == SS) begin
          started = 1'b1;
          t0      = cyc;
          e0      = cyc;
        end
      end else if (was_done && take) begin
        t0 = cyc;
        model_acc++;
      end
    end
  end

  function automatic logic [N-1:0] exp_setn();
    logic [N-1:0] e;
    e = '0;
    if (started)
      for (int k = 0; k < N; k++)
        if (cyc - t0 >= H + k * G) e[k] = 1'b1;
    return e;
  endfunction

  function automatic logic exp_done();
    return started && (cyc - t0 >= LAST);
  endfunction

  function automatic logic exp_done1();
    return started && (cyc - e0 >= 1);
  endfunction

  task automatic assert_rst();
    rst = 1'b1;
    rst_events++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 assert_rst();
    #1;
    n_checks++; if (setn !== 4'b0000) begin n_fail++; $display("FAIL reset_setn: got %b want 0000", setn); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (setn1 !== 1'b0) begin n_fail++; $display("FAIL reset_setn1: got %b want 0", setn1); end
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL reset_busy1: got %b want 1", busy1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1: got %b want 0", done1); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (setn !== 4'b0000 || done !== 1'b0 || setn1 !== 1'b0)
      begin n_fail++; $display("FAIL reset_sync_hold: setn=%b done=%b setn1=%b want 0000/0/0", setn, done, setn1); end
  endtask

  task automatic test_release_sequence();
    logic [N-1:0] prev, rose;
    prev = setn;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      rose = setn & ~prev;
      n_checks++;
      if ({setn, busy, done} !== {exp_setn(), ~exp_done(), exp_done()})
        begin n_fail++; $display("FAIL seq_outputs: cyc=%0d setn/busy/done=%b want %b", cyc, {setn, busy, done}, {exp_setn(), ~exp_done(), exp_done()}); end
      n_checks++;
      if ({setn1, busy1, done1} !== {exp_done1(), ~exp_done1(), exp_done1()})
        begin n_fail++; $display("FAIL seq_single_bank: cyc=%0d setn1/busy1/done1=%b want %b", cyc, {setn1, busy1, done1}, {exp_done1(), ~exp_done1(), exp_done1()}); end
      n_checks++;
      if (busy !== ~done || !((setn & prev) == prev || setn == '0) || (rose & (rose - 1'b1)) != '0)
        begin n_fail++; $display("FAIL seq_invariant: cyc=%0d setn=%b prev=%b busy=%b done=%b", cyc, setn, prev, busy, done); end
      prev = setn;
    end
    n_checks++;
    if (setn !== 4'b1111 || done !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL seq_final: setn=%b done=%b busy=%b want 1111/1/0", setn, done, busy); end
  endtask

  task automatic test_req_pulse();
    logic [N-1:0] prev;
    int pulse_at, dut_acc;
    dut_acc  = 0;
    pulse_at = $urandom_range(10, 18);
    for (int i = 0; i < 100 && !exp_done(); i++) @(negedge clk);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    prev = setn;
    req  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req = (i == pulse_at);
      if (prev == '1 && setn == '0) dut_acc++;
      n_checks++;
      if ({setn, busy, done} !== {exp_setn(), ~exp_done(), exp_done()})
        begin n_fail++; $display("FAIL req_pulse_outputs: cyc=%0d setn/busy/done=%b want %b", cyc, {setn, busy, done}, {exp_setn(), ~exp_done(), exp_done()}); end
      prev = setn;
    end
    req = 1'b0;
    n_checks++;
    if (dut_acc !== 1) begin n_fail++; $display("FAIL req_pulse_count: re-presets=%0d want 1", dut_acc); end
  endtask

  task automatic test_req_held();
    logic [N-1:0] prev;
    int dut_acc, want;
    dut_acc = 0;
`ifdef SETN_SEQ_REQ_SYNC_EN
    want = 1;
`else
    want = 2;
`endif
    for (int i = 0; i < 100 && !exp_done(); i++) @(negedge clk);
    prev = setn;
    req  = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (i == 49) req = 1'b0;
      if (prev == '1 && setn == '0) dut_acc++;
      n_checks++;
      if ({setn, busy, done} !== {exp_setn(), ~exp_done(), exp_done()})
        begin n_fail++; $display("FAIL req_held_outputs: cyc=%0d setn/busy/done=%b want %b", cyc, {setn, busy, done}, {exp_setn(), ~exp_done(), exp_done()}); end
      prev = setn;
    end
    n_checks++;
    if (dut_acc !== want) begin n_fail++; $display("FAIL req_held_count: re-presets=%0d want %0d", dut_acc, want); end
  endtask

  task automatic test_mid_reset();
    int target;
    @(negedge clk);
    #2 assert_rst();
    @(negedge clk);
    rst = 1'b0;
    target = $urandom_range(5, 25);
    for (int i = 0; i < 100 && !(started && cyc - t0 >= target); i++) @(negedge clk);
    #2 assert_rst();
    #1;
    n_checks++;
    if (setn !== 4'b0000 || busy !== 1'b1 || done !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset_async: setn=%b busy=%b done=%b want 0000/1/0", setn, busy, done); end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      n_checks++;
      if ({setn, busy, done} !== {exp_setn(), ~exp_done(), exp_done()})
        begin n_fail++; $display("FAIL mid_reset_replay: cyc=%0d setn/busy/done=%b want %b", cyc, {setn, busy, done}, {exp_setn(), ~exp_done(), exp_done()}); end
    end
    // sub-cycle pulse between two edges
    #2 assert_rst();
    #1;
    n_checks++;
    if (setn !== 4'b0000 || busy !== 1'b1 || done !== 1'b0)
      begin n_fail++; $display("FAIL short_reset_async: setn=%b busy=%b done=%b want 0000/1/0", setn, busy, done); end
    #1 rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      n_checks++;
      if ({setn, busy, done} !== {exp_setn(), ~exp_done(), exp_done()})
        begin n_fail++; $display("FAIL short_reset_replay: cyc=%0d setn/busy/done=%b want %b", cyc, {setn, busy, done}, {exp_setn(), ~exp_done(), exp_done()}); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] prev, rose;
    int rst_hold;
    rst_hold = 0;
    prev = setn;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rose = setn & ~prev;
      n_checks++;
      if ({setn, busy, done} !== {exp_setn(), ~exp_done(), exp_done()})
        begin n_fail++; $display("FAIL random_outputs: cyc=%0d setn/busy/done=%b want %b", cyc, {setn, busy, done}, {exp_setn(), ~exp_done(), exp_done()}); end
      n_checks++;
      if (busy !== ~done || !((setn & prev) == prev || setn == '0) || (rose & (rose - 1'b1)) != '0)
        begin n_fail++; $display("FAIL random_invariant: cyc=%0d setn=%b prev=%b busy=%b done=%b", cyc, setn, prev, busy, done); end
      prev = setn;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        #2 assert_rst();
        #1 rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        assert_rst();
        rst_hold = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 7) == 0) req = ~req;
    end
    rst = 1'b0;
    req = 1'b0;
  endtask

  initial begin
    #1 assert_rst();
    test_reset();
    test_release_sequence();
    test_req_pulse();
    test_req_held();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
